xgriscv_mem_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the pipeline's instruction-fetch port (IF, driven by pcF)
//  and its data port (MEM stage: load/store with byte-enable amp). Grants one requester at a time and

---
 rtl/xgriscv_mem_arbiter_if.sv | 47 ++++
 rtl/xgriscv_mem_arbiter.sv | 127 ++++++++++++
 tb/tb_xgriscv_mem_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/xgriscv_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// xgriscv_mem_arbiter_if
//   Bundles the fetch port, the data port and the unified-memory port
//   of the memory arbiter.
//   slave  : arbiter side  (takes requests and read data, drives acks/mem_*)
//   master : requester/memory side (drives requests and mem_rdata)
// ---------------------------------------------------------------------------
interface xgriscv_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // instruction fetch port
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ack;
   // data port
   logic              d_req;
   logic              d_we;
   logic [3:0]        d_amp;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ack;
   // unified memory port
   logic              mem_en;
   logic              mem_we;
   logic [3:0]        mem_amp;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   // stalls toward hazard logic
   logic              stallF;
   logic              stallM;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_amp, d_addr, d_wdata, mem_rdata,
      output if_rdata, if_ack, d_rdata, d_ack,
             mem_en, mem_we, mem_amp, mem_addr, mem_wdata, stallF, stallM
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_amp, d_addr, d_wdata, mem_rdata,
      input  if_rdata, if_ack, d_rdata, d_ack,
             mem_en, mem_we, mem_amp, mem_addr, mem_wdata, stallF, stallM
   );
endinterface

// File: rtl/xgriscv_mem_arbiter.sv
// ---------------------------------------------------------------------------
// xgriscv_mem_arbiter
//   Shares one single-ported, fixed-latency memory between instruction fetch
//   and the MEM-stage data port. One access in flight at a time:
//   IDLE -> ISSUE -> WAIT (MEM_LAT-1 cycles) -> RESP -> IDLE.
//   Ports:
//     i_clk    clock, rising edge
//     i_reset  synchronous, active-high reset
//     bus      xgriscv_mem_arbiter_if.slave (fetch, data, memory, stalls)
// ---------------------------------------------------------------------------
module xgriscv_mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   xgriscv_mem_arbiter_if.slave  bus
);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int WW = $clog2(MEM_LAT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t            r_state;
   logic              r_own_f;     // 1 = current access belongs to fetch
   logic [SW-1:0]     r_starve;
   logic [WW-1:0]     r_wcnt;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [3:0]        r_mem_amp;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_if_ack;
   logic              r_d_ack;

   logic w_any_req;
   logic w_pick_f;

   // Data (older instruction) wins unless fetch has been passed over
   // STARVE_MAX grants in a row.
   assign w_any_req = bus.if_req | bus.d_req;
   assign w_pick_f  = bus.if_req & (~bus.d_req | (r_starve == SW'(STARVE_MAX)));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_own_f     <= 1'b0;
         r_starve    <= '0;
         r_wcnt      <= '0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_amp   <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_ack    <= 1'b0;
         r_d_ack     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_state  <= S_ISSUE;
                  r_mem_en <= 1'b1;
                  r_own_f  <= w_pick_f;
                  if (w_pick_f) begin
                     r_mem_we    <= 1'b0;
                     r_mem_amp   <= '0;
                     r_mem_addr  <= bus.if_addr;
                     r_mem_wdata <= '0;
                     r_starve    <= '0;
                  end else begin
                     r_mem_we    <= bus.d_we;
                     r_mem_amp   <= bus.d_amp;
                     r_mem_addr  <= bus.d_addr;
                     r_mem_wdata <= bus.d_wdata;
                     if (!bus.if_req)
                        r_starve <= '0;
                     else if (r_starve != SW'(STARVE_MAX))
                        r_starve <= r_starve + 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               r_mem_en <= 1'b0;
               if (MEM_LAT == 1) begin
                  r_state  <= S_RESP;
                  r_if_ack <= r_own_f;
                  r_d_ack  <= ~r_own_f;
               end else begin
                  r_state <= S_WAIT;
                  r_wcnt  <= WW'(MEM_LAT - 2);
               end
            end
            S_WAIT: begin
               if (r_wcnt == '0) begin
                  r_state  <= S_RESP;
                  r_if_ack <= r_own_f;
                  r_d_ack  <= ~r_own_f;
               end else begin
                  r_wcnt <= r_wcnt - 1'b1;
               end
            end
            S_RESP: begin
               // no arbitration here: a request seen in RESP is served from IDLE
               r_state  <= S_IDLE;
               r_if_ack <= 1'b0;
               r_d_ack  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.mem_en    = r_mem_en;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_amp   = r_mem_amp;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.if_ack    = r_if_ack;
   assign bus.d_ack     = r_d_ack;
   // read data passes straight through from memory, only during the ack cycle
   assign bus.if_rdata  = r_if_ack ? bus.mem_rdata : '0;
   assign bus.d_rdata   = r_d_ack  ? bus.mem_rdata : '0;
   assign bus.stallF    = bus.if_req & ~r_if_ack;
   assign bus.stallM    = bus.d_req  & ~r_d_ack;
endmodule

// File: tb/tb_xgriscv_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_xgriscv_mem_arbiter
//   Directed bench for the memory arbiter (MEM_LAT=2, STARVE_MAX=4).
//   The memory model returns data only in the cycle MEM_LAT after mem_en;
//   any other cycle it shows a poison value.
// ---------------------------------------------------------------------------
module tb_xgriscv_mem_arbiter;
   localparam int MEM_LAT = 2;

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [MEM_LAT:0] vpipe;

   xgriscv_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   xgriscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(4)) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset) vpipe <= '0;
      else       vpipe <= {vpipe[MEM_LAT-1:0], bus.mem_en};
   end

   assign bus.mem_rdata = !vpipe[MEM_LAT-1]      ? 32'hBAD0_BAD0 :
                          (bus.mem_addr == 32'h100) ? 32'h0050_0093 : ~bus.mem_addr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.if_req = 1'b0; bus.d_req = 1'b0;
      nxt(); nxt();
      reset = 1'b0;
   endtask

   // Store (or dropped store) starting at cycle 0; checks cycles 0..3.
   task automatic store_seq(input string nm, input logic [3:0] amp, input bit drop);
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_amp = amp;
      bus.d_addr = 32'h2004; bus.d_wdata = 32'hDEAD_BEEF;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("%s.en c%0d", nm, c), bus.mem_en, (c == 1));
         chk($sformatf("%s.dack c%0d", nm, c), bus.d_ack, (c == 3));
         chk($sformatf("%s.stallM c%0d", nm, c), bus.stallM, (c < 3) && (!drop || c == 0));
         if (c >= 1) begin
            chk($sformatf("%s.we c%0d", nm, c), bus.mem_we, 1'b1);
            chk($sformatf("%s.amp c%0d", nm, c), bus.mem_amp, amp);
            chk($sformatf("%s.addr c%0d", nm, c), bus.mem_addr, 32'h2004);
            chk($sformatf("%s.wdata c%0d", nm, c), bus.mem_wdata, 32'hDEAD_BEEF);
         end
         nxt();
         if (drop) bus.d_req = 1'b0;
      end
      bus.d_req = 1'b0;
   endtask

   initial begin
      int        n;
      logic [9:0] order;
      int         g;
      reset = 1'b1;
      bus.if_req = 1'b1; bus.if_addr = 32'h100;
      bus.d_req = 1'b1;  bus.d_we = 1'b0; bus.d_amp = 4'h0;
      bus.d_addr = 32'h2000; bus.d_wdata = 32'h0;

      // 1. reset with both requests high
      nxt(); nxt();
      @(negedge clk);
      chk("rst.en", bus.mem_en, 1'b0);
      chk("rst.we", bus.mem_we, 1'b0);
      chk("rst.amp", bus.mem_amp, 4'h0);
      chk("rst.addr", bus.mem_addr, 32'h0);
      chk("rst.wdata", bus.mem_wdata, 32'h0);
      chk("rst.iack", bus.if_ack, 1'b0);
      chk("rst.dack", bus.d_ack, 1'b0);
      chk("rst.irdata", bus.if_rdata, 32'h0);
      chk("rst.drdata", bus.d_rdata, 32'h0);
      nxt();
      reset = 1'b0;
      @(negedge clk);
      chk("rst.c0.en", bus.mem_en, 1'b0);
      nxt();
      @(negedge clk);
      chk("rst.c1.en", bus.mem_en, 1'b1);
      chk("rst.c1.addr", bus.mem_addr, 32'h2000);
      nxt();
      do_reset();

      // 2. single fetch
      bus.if_req = 1'b1; bus.if_addr = 32'h100;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("f.en c%0d", c), bus.mem_en, (c == 1));
         chk($sformatf("f.stallF c%0d", c), bus.stallF, (c < 3));
         chk($sformatf("f.iack c%0d", c), bus.if_ack, (c == 3));
         if (c >= 1) begin
            chk($sformatf("f.addr c%0d", c), bus.mem_addr, 32'h100);
            chk($sformatf("f.we c%0d", c), bus.mem_we, 1'b0);
         end
         if (c == 3) chk("f.rdata", bus.if_rdata, 32'h0050_0093);
         nxt();
      end
      bus.if_req = 1'b0;
      @(negedge clk);
      chk("f.c4.en", bus.mem_en, 1'b0);
      nxt();
      do_reset();

      // 3. store, store with no byte enables, store with illegal req drop
      store_seq("st", 4'b0011, 1'b0);
      do_reset();
      store_seq("st0", 4'b0000, 1'b0);
      do_reset();
      store_seq("stdrop", 4'b1111, 1'b1);
      do_reset();

      // 4. both requests: data first, then fetch
      bus.if_req = 1'b1; bus.if_addr = 32'h100;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_amp = 4'h0; bus.d_addr = 32'h2004;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk($sformatf("both.en c%0d", c), bus.mem_en, (c == 1 || c == 5));
         chk($sformatf("both.dack c%0d", c), bus.d_ack, (c == 3));
         chk($sformatf("both.iack c%0d", c), bus.if_ack, (c == 7));
         if (c == 1) chk("both.daddr", bus.mem_addr, 32'h2004);
         if (c == 3) chk("both.drdata", bus.d_rdata, ~32'h2004);
         if (c == 5) chk("both.iaddr", bus.mem_addr, 32'h100);
         if (c == 7) chk("both.irdata", bus.if_rdata, 32'h0050_0093);
         nxt();
         if (c == 3) bus.d_req = 1'b0;
      end
      bus.if_req = 1'b0;
      do_reset();

      // 5. starvation: both held high, grant order D,D,D,D,F,D,D,D,D,F
      bus.if_req = 1'b1; bus.if_addr = 32'h400;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h800;
      order = '0;
      g = 0;
      for (int c = 0; c < 80 && g < 10; c++) begin
         @(negedge clk);
         if (bus.mem_en) begin
            order[g] = (bus.mem_addr == 32'h400);
            g++;
         end
         nxt();
      end
      chk("starve.grants", g, 10);
      chk("starve.order", {22'h0, order}, 32'h210);
      do_reset();

      // 6. reset during WAIT, then a clean fetch
      bus.if_req = 1'b1; bus.if_addr = 32'h300;
      nxt(); nxt();          // now in cycle 2 (WAIT)
      reset = 1'b1;
      nxt();                 // cycle 3: would have been RESP
      @(negedge clk);
      chk("rw.iack", bus.if_ack, 1'b0);
      chk("rw.irdata", bus.if_rdata, 32'h0);
      chk("rw.en", bus.mem_en, 1'b0);
      chk("rw.addr", bus.mem_addr, 32'h0);
      chk("rw.stallF", bus.stallF, 1'b1);
      nxt();
      reset = 1'b0;
      n = -1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.if_ack) begin
            n = c;
            chk("rw.rdata", bus.if_rdata, ~32'h300);
            break;
         end
         nxt();
      end
      chk("rw.lat", n, MEM_LAT + 1);
      nxt();
      bus.if_req = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
